// File: rtl/ula_bist_pkg.sv
// ---------------------------------------------------------------------------
// ula_bist_pkg
// Shared definitions for the ula built-in self-test block:
//   - default operand / op-code / error-counter widths
//   - ula op-code set (must stay in sync with the ula itself)
//   - sequencer FSM state encoding
//   - op_supported(): membership test for the op-code set
// ---------------------------------------------------------------------------
package ula_bist_pkg;

  localparam int DEF_BITS  = 8;   // operand / result width
  localparam int DEF_OPW   = 8;   // op-code width
  localparam int DEF_ERR_W = 16;  // error counter width

  localparam logic [DEF_OPW-1:0] ULA_OP_ADD = 8'h00;
  localparam logic [DEF_OPW-1:0] ULA_OP_SUB = 8'h01;
  localparam logic [DEF_OPW-1:0] ULA_OP_AND = 8'h02;
  localparam logic [DEF_OPW-1:0] ULA_OP_XOR = 8'h03;
  localparam logic [DEF_OPW-1:0] ULA_OP_OR  = 8'h04;
  localparam logic [DEF_OPW-1:0] ULA_OP_NOT = 8'h05;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // True when the op code belongs to the set the golden model can check.
  function automatic logic op_supported(input logic [DEF_OPW-1:0] op);
    case (op)
      ULA_OP_ADD, ULA_OP_SUB, ULA_OP_AND,
      ULA_OP_XOR, ULA_OP_OR,  ULA_OP_NOT: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ula_bist_if.sv
// ---------------------------------------------------------------------------
// ula_bist_if
// Operand/result bus between the BIST sequencer and the combinational ula.
//   a, b    operands driven by the sequencer
//   op      op code driven by the sequencer
//   result  ula output returned to the sequencer (same cycle)
// Modports:
//   master  sequencer side (drives a/b/op, samples result)
//   slave   ula side (receives a/b/op, drives result)
// ---------------------------------------------------------------------------
interface ula_bist_if
  import ula_bist_pkg::*;
#(
  parameter int BITS = DEF_BITS,
  parameter int OPW  = DEF_OPW
) ();

  logic [BITS-1:0] a;
  logic [BITS-1:0] b;
  logic [OPW-1:0]  op;
  logic [BITS-1:0] result;

  modport master (output a, output b, output op, input result);
  modport slave  (input a, input b, input op, output result);

endinterface

// File: rtl/ula_bist_golden.sv
// ---------------------------------------------------------------------------
// ula_bist_golden
// Combinational reference model of the ula used by the BIST sequencer.
// Ports:
//   op_i         op code under test
//   a_i, b_i     operands
//   expected_o   reference result, truncated to BITS
//   supported_o  1 when op_i is in the ula op-code set
// ---------------------------------------------------------------------------
module ula_bist_golden
  import ula_bist_pkg::*;
#(
  parameter int BITS = DEF_BITS,
  parameter int OPW  = DEF_OPW
) (
  input  logic [OPW-1:0]  op_i,
  input  logic [BITS-1:0] a_i,
  input  logic [BITS-1:0] b_i,
  output logic [BITS-1:0] expected_o,
  output logic            supported_o
);

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path through the case leaves it unassigned (which would infer a latch).
    expected_o  = '0;
    supported_o = op_supported(op_i);
    case (op_i)
      ULA_OP_ADD: expected_o = a_i + b_i;   // wraps modulo 2^BITS
      ULA_OP_SUB: expected_o = a_i - b_i;   // wraps modulo 2^BITS
      ULA_OP_AND: expected_o = a_i & b_i;
      ULA_OP_XOR: expected_o = a_i ^ b_i;
      ULA_OP_OR:  expected_o = a_i | b_i;
      ULA_OP_NOT: expected_o = ~a_i;
      default:    expected_o = '0;
    endcase
  end

endmodule

// File: rtl/ula_bist.sv
// ---------------------------------------------------------------------------
// ula_bist
// Built-in self-test sequencer for the combinational ula. On start it sweeps
// every (a, b) operand pair for one op code, one vector per clock, compares
// the ula result against an internal golden model in the same cycle, and
// reports pass/fail, a saturating error count and the first failing pair.
// Ports:
//   clk_in         clock, all state on the rising edge
//   rst_in         asynchronous active-high reset
//   start_in       begin sweep (accepted only in IDLE/DONE)
//   abort_in       stop and return to IDLE (wins over start_in)
//   op_sel_in      op code to test, latched on an accepted start
//   ula            operand/result bus to the ula (master side)
//   busy_out       high while sweeping
//   done_out       high after a completed sweep until start/abort/reset
//   pass_out       valid with done_out: no mismatches and op supported
//   err_count_out  mismatches in the current/last sweep (saturating)
//   fail_a_out     operand a of the first mismatch (0 if none)
//   fail_b_out     operand b of the first mismatch (0 if none)
// ---------------------------------------------------------------------------
module ula_bist
  import ula_bist_pkg::*;
#(
  parameter int BITS  = DEF_BITS,
  parameter int OPW   = DEF_OPW,
  parameter int ERR_W = DEF_ERR_W
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             start_in,
  input  logic             abort_in,
  input  logic [OPW-1:0]   op_sel_in,
  ula_bist_if.master       ula,
  output logic             busy_out,
  output logic             done_out,
  output logic             pass_out,
  output logic [ERR_W-1:0] err_count_out,
  output logic [BITS-1:0]  fail_a_out,
  output logic [BITS-1:0]  fail_b_out
);

  localparam logic [2*BITS-1:0] AB_ONE  = {{(2*BITS-1){1'b0}}, 1'b1};
  localparam logic [ERR_W-1:0]  ERR_ONE = {{(ERR_W-1){1'b0}}, 1'b1};

  state_e           state_q;
  logic [BITS-1:0]  a_q, b_q;
  logic [OPW-1:0]   op_q;
  logic             busy_q, done_q, pass_q;
  logic [ERR_W-1:0] err_q;
  logic [BITS-1:0]  fail_a_q, fail_b_q;
  logic             fail_seen_q;

  logic [BITS-1:0]   expected;
  logic              supported;
  logic              mismatch;
  logic              last_vec;
  logic [2*BITS-1:0] ab_d;
  logic [ERR_W-1:0]  err_d;

  ula_bist_golden #(
    .BITS (BITS),
    .OPW  (OPW)
  ) u_golden (
    .op_i        (op_q),
    .a_i         (a_q),
    .b_i         (b_q),
    .expected_o  (expected),
    .supported_o (supported)
  );

  // The ula is combinational: its result for the registered operands is
  // already valid in the cycle they are presented.
  assign mismatch = (ula.result != expected);
  assign last_vec = (&a_q) && (&b_q);

  // {a, b} behaves as one counter: b wrapping to 0 carries into a.
  assign ab_d  = {a_q, b_q} + AB_ONE;
  assign err_d = (mismatch && (err_q != '1)) ? (err_q + ERR_ONE) : err_q;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_q       <= '0;
      fail_a_q    <= '0;
      fail_b_q    <= '0;
      fail_seen_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (abort_in) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
          end else if (start_in) begin
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= op_sel_in;
            err_q       <= '0;
            fail_a_q    <= '0;
            fail_b_q    <= '0;
            fail_seen_q <= 1'b0;
            pass_q      <= 1'b0;
            if (op_supported(op_sel_in)) begin
              state_q <= ST_RUN;
              busy_q  <= 1'b1;
              done_q  <= 1'b0;
            end else begin
              // Nothing to sweep: report a failed test immediately.
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end

        ST_RUN: begin
          if (abort_in) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
          end else begin
            err_q <= err_d;
            if (mismatch && !fail_seen_q) begin
              fail_a_q    <= a_q;
              fail_b_q    <= b_q;
              fail_seen_q <= 1'b1;
            end
            if (last_vec) begin
              // Operands hold the final vector while in DONE.
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= supported && (err_d == '0);
            end else begin
              {a_q, b_q} <= ab_d;
            end
          end
        end

        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          pass_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ula.a         = a_q;
  assign ula.b         = b_q;
  assign ula.op        = op_q;
  assign busy_out      = busy_q;
  assign done_out      = done_q;
  assign pass_out      = pass_q;
  assign err_count_out = err_q;
  assign fail_a_out    = fail_a_q;
  assign fail_b_out    = fail_b_q;

endmodule

// File: tb/tb_ula_bist.sv
// ---------------------------------------------------------------------------
// tb_ula_bist
// Directed bench for ula_bist. Three sequencer instances share one clock and
// reset, each paired with a behavioural ula that can be corrupted:
//   dut8  BITS=8            full sweep with one flipped result bit
//   dut4  BITS=4            pass sweeps, stuck-at, abort, unsupported op,
//                           start-while-busy, reset mid-sweep
//   duts  BITS=2, ERR_W=2   error counter saturation
// ---------------------------------------------------------------------------
module tb_ula_bist;
  import ula_bist_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Behavioural ula shared by all instances (8-bit, truncated per instance).
  function automatic logic [7:0] ula_ref(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      8'h00:   return a + b;
      8'h01:   return a - b;
      8'h02:   return a & b;
      8'h03:   return a ^ b;
      8'h04:   return a | b;
      8'h05:   return ~a;
      default: return 8'h00;
    endcase
  endfunction

  // ---------------- dut8 ----------------
  ula_bist_if #(.BITS(8), .OPW(8)) if8 ();
  logic        start8, abort8, fault8;
  logic [7:0]  op8;
  logic        busy8, done8, pass8;
  logic [15:0] err8;
  logic [7:0]  fa8, fb8;

  assign if8.result = ula_ref(if8.op, if8.a, if8.b)
                      ^ {7'b0, (fault8 && if8.a == 8'h12 && if8.b == 8'h34)};

  ula_bist #(.BITS(8), .OPW(8), .ERR_W(16)) dut8 (
    .clk_in(clk), .rst_in(rst), .start_in(start8), .abort_in(abort8),
    .op_sel_in(op8), .ula(if8), .busy_out(busy8), .done_out(done8),
    .pass_out(pass8), .err_count_out(err8), .fail_a_out(fa8), .fail_b_out(fb8)
  );

  // ---------------- dut4 ----------------
  ula_bist_if #(.BITS(4), .OPW(8)) if4 ();
  logic        start4, abort4, stuck4;
  logic [7:0]  op4;
  logic        busy4, done4, pass4;
  logic [15:0] err4;
  logic [3:0]  fa4, fb4;
  logic [7:0]  r4;

  assign r4         = ula_ref(if4.op, 8'(if4.a), 8'(if4.b));
  assign if4.result = stuck4 ? 4'h0 : r4[3:0];

  ula_bist #(.BITS(4), .OPW(8), .ERR_W(16)) dut4 (
    .clk_in(clk), .rst_in(rst), .start_in(start4), .abort_in(abort4),
    .op_sel_in(op4), .ula(if4), .busy_out(busy4), .done_out(done4),
    .pass_out(pass4), .err_count_out(err4), .fail_a_out(fa4), .fail_b_out(fb4)
  );

  // ---------------- duts (saturation) ----------------
  ula_bist_if #(.BITS(2), .OPW(8)) ifs ();
  logic       starts, aborts;
  logic [7:0] ops;
  logic       busys, dones, passs;
  logic [1:0] errs;
  logic [1:0] fas, fbs;

  assign ifs.result = 2'b00;   // permanently stuck at zero

  ula_bist #(.BITS(2), .OPW(8), .ERR_W(2)) duts (
    .clk_in(clk), .rst_in(rst), .start_in(starts), .abort_in(aborts),
    .op_sel_in(ops), .ula(ifs), .busy_out(busys), .done_out(dones),
    .pass_out(passs), .err_count_out(errs), .fail_a_out(fas), .fail_b_out(fbs)
  );

  // ---------------- dut4 helpers ----------------
  task automatic pulse_start4(input logic [7:0] op);
    op4    = op;
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
  endtask

  // Counts sampled busy cycles until done, bounded by a guard.
  task automatic wait_done4(output int cycles);
    int guard;
    cycles = 0;
    guard  = 0;
    while (!done4 && guard < 1000) begin
      if (busy4) cycles++;
      guard++;
      @(negedge clk);
    end
  endtask

  int               cyc;
  logic [7:0]       pass_ops [5] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h05};
  logic [7:0]       stuck_ops[3] = '{8'h03, 8'h00, 8'h05};
  logic [3:0]       stuck_fb [3] = '{4'h1, 4'h1, 4'h0};

  initial begin
    rst = 1'b1;
    start8 = 1'b0; abort8 = 1'b0; fault8 = 1'b0; op8 = 8'h00;
    start4 = 1'b0; abort4 = 1'b0; stuck4 = 1'b0; op4 = 8'h00;
    starts = 1'b0; aborts = 1'b0; ops = 8'h00;

    repeat (2) @(negedge clk);
    check("rst_busy4", busy4, 0);
    check("rst_done4", done4, 0);
    check("rst_pass4", pass4, 0);
    check("rst_err4",  err4,  0);
    check("rst_ab4",   {if4.a, if4.b}, 0);
    check("rst_op8",   if8.op, 0);
    rst = 1'b0;
    @(negedge clk);

    // Correct ula, XOR: 256 cycles, pass, operands hold the final vector.
    pulse_start4(8'h03);
    check("xor_busy",  busy4, 1);
    check("xor_ab0",   {if4.a, if4.b}, 0);
    check("xor_op",    if4.op, 8'h03);
    wait_done4(cyc);
    check("xor_cycles", cyc, 256);
    check("xor_done",   done4, 1);
    check("xor_pass",   pass4, 1);
    check("xor_err",    err4, 0);
    check("xor_fail",   {fa4, fb4}, 0);
    check("xor_hold_ab", {if4.a, if4.b}, 8'hFF);
    @(negedge clk);
    check("xor_done_hold", done4, 1);
    check("xor_busy_off",  busy4, 0);

    // Remaining ops against a correct ula, restarted straight from DONE.
    foreach (pass_ops[i]) begin
      pulse_start4(pass_ops[i]);
      wait_done4(cyc);
      check($sformatf("op%0h_cycles", pass_ops[i]), cyc, 256);
      check($sformatf("op%0h_pass",   pass_ops[i]), pass4, 1);
      check($sformatf("op%0h_err",    pass_ops[i]), err4, 0);
    end

    // Stuck-at-zero result: XOR/ADD/NOT each agree on exactly 16 pairs.
    stuck4 = 1'b1;
    foreach (stuck_ops[i]) begin
      pulse_start4(stuck_ops[i]);
      wait_done4(cyc);
      check($sformatf("stuck%0h_err",  stuck_ops[i]), err4, 240);
      check($sformatf("stuck%0h_fa",   stuck_ops[i]), fa4, 0);
      check($sformatf("stuck%0h_fb",   stuck_ops[i]), fb4, stuck_fb[i]);
      check($sformatf("stuck%0h_pass", stuck_ops[i]), pass4, 0);
    end
    stuck4 = 1'b0;

    // Abort at vector 100 (a=6, b=4), then restart from zero.
    pulse_start4(8'h03);
    repeat (100) @(negedge clk);
    check("abort_pre_ab", {if4.a, if4.b}, 8'h64);
    abort4 = 1'b1;
    @(negedge clk);
    abort4 = 1'b0;
    check("abort_busy", busy4, 0);
    check("abort_done", done4, 0);
    @(negedge clk);
    check("abort_idle", busy4, 0);
    pulse_start4(8'h03);
    check("restart_ab", {if4.a, if4.b}, 0);
    check("restart_busy", busy4, 1);

    // Start while busy is ignored: op and sweep position unaffected.
    repeat (10) @(negedge clk);
    pulse_start4(8'h00);
    check("busy_start_op", if4.op, 8'h03);
    check("busy_start_ab", {if4.a, if4.b}, 8'h0B);
    wait_done4(cyc);
    check("busy_start_rest", cyc, 245);
    check("busy_start_pass", pass4, 1);

    // Abort and start together in DONE: abort wins.
    op4 = 8'h03; start4 = 1'b1; abort4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0; abort4 = 1'b0;
    check("abort_wins_busy", busy4, 0);
    check("abort_wins_done", done4, 0);
    check("abort_wins_pass", pass4, 0);

    // Unsupported op: DONE after one cycle, fail, no errors counted.
    pulse_start4(8'hFF);
    check("unsup_done", done4, 1);
    check("unsup_busy", busy4, 0);
    check("unsup_pass", pass4, 0);
    check("unsup_err",  err4, 0);
    check("unsup_op",   if4.op, 8'hFF);

    // Saturation: 12 mismatching pairs into a 2-bit counter.
    ops = 8'h03; starts = 1'b1;
    @(negedge clk);
    starts = 1'b0;
    repeat (20) @(negedge clk);
    check("sat_done", dones, 1);
    check("sat_err",  errs, 3);
    check("sat_fail", {fas, fbs}, 4'b0001);
    check("sat_pass", passs, 0);
    check("sat_busy", busys, 0);

    // Full 8-bit sweep with a single corrupted vector.
    fault8 = 1'b1;
    op8 = 8'h03; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    check("f8_busy", busy8, 1);
    cyc = 0;
    for (int guard = 0; guard < 70000 && !done8; guard++) begin
      if (busy8) cyc++;
      @(negedge clk);
    end
    check("f8_cycles", cyc, 65536);
    check("f8_done",   done8, 1);
    check("f8_err",    err8, 1);
    check("f8_fa",     fa8, 8'h12);
    check("f8_fb",     fb8, 8'h34);
    check("f8_pass",   pass8, 0);
    fault8 = 1'b0;

    // Reset between clock edges mid-sweep clears everything at once.
    stuck4 = 1'b1;
    pulse_start4(8'h03);
    repeat (50) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("mrst_busy4", busy4, 0);
    check("mrst_err4",  err4, 0);
    check("mrst_fail4", {fa4, fb4}, 0);
    check("mrst_ab4",   {if4.a, if4.b}, 0);
    check("mrst_op4",   if4.op, 0);
    check("mrst_err8",  err8, 0);
    check("mrst_done8", done8, 0);
    @(negedge clk);
    rst = 1'b0;
    stuck4 = 1'b0;
    @(negedge clk);
    check("mrst_stay_idle", busy4, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
